// File: rtl/jtag_tap_responder.sv
// jtag_tap_responder: IEEE 1149.1 TAP target oversampling TCK on clk_i, with IR, BYPASS, IDCODE and a user DR.
// Define JTAG_TAP_INPUT_SYNC_EN to pass the JTAG inputs through 2-flop synchronizers.
module jtag_tap_responder #(
    parameter int                      IR_WIDTH      = 5,
    parameter logic [31:0]             IDCODE_VAL    = 32'h1000_0CAD,
    parameter logic [IR_WIDTH-1:0]     IR_IDCODE     = 5'h01,
    parameter logic [IR_WIDTH-1:0]     IR_USER       = 5'h11,
    parameter int                      USER_DR_WIDTH = 41
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     jtag_tck,
    input  logic                     jtag_tms,
    input  logic                     jtag_tdi,
    input  logic                     jtag_trst_n,
    output logic                     jtag_tdo,
    output logic [3:0]               tap_state_o,
    output logic [IR_WIDTH-1:0]      ir_o,
    input  logic [USER_DR_WIDTH-1:0] user_capture_data_i,
    output logic                     user_capture_o,
    output logic                     user_update_o,
    output logic [USER_DR_WIDTH-1:0] user_update_data_o
);
    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC,
        SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
        PA_DR  = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
        SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR = 4'hA, EX1_IR = 4'h9,
        PA_IR  = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } state_t;

    state_t                   state, nxt;
    logic                     tck, tms, tdi, trst_n, tck_q, tck_rise, tck_fall;
    logic [IR_WIDTH-1:0]      ir_sr;
    logic [31:0]              id_sr;
    logic [USER_DR_WIDTH-1:0] user_sr;
    logic                     byp, sel_id, sel_user, dr_lsb;

`ifdef JTAG_TAP_INPUT_SYNC_EN
    logic [1:0] tck_s, tms_s, tdi_s, trst_s;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tck_s  <= 2'b00;
            tms_s  <= 2'b00;
            tdi_s  <= 2'b00;
            trst_s <= 2'b11;
        end else begin
            tck_s  <= {tck_s[0], jtag_tck};
            tms_s  <= {tms_s[0], jtag_tms};
            tdi_s  <= {tdi_s[0], jtag_tdi};
            trst_s <= {trst_s[0], jtag_trst_n};
        end
    end
    assign tck    = tck_s[1];
    assign tms    = tms_s[1];
    assign tdi    = tdi_s[1];
    assign trst_n = trst_s[1];
`else
    assign tck    = jtag_tck;
    assign tms    = jtag_tms;
    assign tdi    = jtag_tdi;
    assign trst_n = jtag_trst_n;
`endif

    assign tck_rise    = tck & ~tck_q;
    assign tck_fall    = ~tck & tck_q;
    assign sel_id      = ir_o == IR_IDCODE;
    assign sel_user    = ir_o == IR_USER;
    assign dr_lsb      = sel_id ? id_sr[0] : sel_user ? user_sr[0] : byp;
    assign tap_state_o = state;

    always_comb begin
        nxt = state;
        case (state)
            TLR:     nxt = tms ? TLR    : RTI;
            RTI:     nxt = tms ? SEL_DR : RTI;
            SEL_DR:  nxt = tms ? SEL_IR : CAP_DR;
            CAP_DR:  nxt = tms ? EX1_DR : SH_DR;
            SH_DR:   nxt = tms ? EX1_DR : SH_DR;
            EX1_DR:  nxt = tms ? UPD_DR : PA_DR;
            PA_DR:   nxt = tms ? EX2_DR : PA_DR;
            EX2_DR:  nxt = tms ? UPD_DR : SH_DR;
            UPD_DR:  nxt = tms ? SEL_DR : RTI;
            SEL_IR:  nxt = tms ? TLR    : CAP_IR;
            CAP_IR:  nxt = tms ? EX1_IR : SH_IR;
            SH_IR:   nxt = tms ? EX1_IR : SH_IR;
            EX1_IR:  nxt = tms ? UPD_IR : PA_IR;
            PA_IR:   nxt = tms ? EX2_IR : PA_IR;
            EX2_IR:  nxt = tms ? UPD_IR : SH_IR;
            UPD_IR:  nxt = tms ? SEL_DR : RTI;
            default: nxt = TLR;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state              <= TLR;
            tck_q              <= 1'b0;
            ir_o               <= IR_IDCODE;
            ir_sr              <= '0;
            id_sr              <= '0;
            user_sr            <= '0;
            byp                <= 1'b0;
            jtag_tdo           <= 1'b0;
            user_capture_o     <= 1'b0;
            user_update_o      <= 1'b0;
            user_update_data_o <= '0;
        end else begin
            tck_q          <= tck;
            user_capture_o <= 1'b0;
            user_update_o  <= 1'b0;
            // TAP reset wins over any TCK edge seen in the same cycle
            if (!trst_n) begin
                state    <= TLR;
                ir_o     <= IR_IDCODE;
                jtag_tdo <= 1'b0;
            end else if (tck_rise) begin
                state <= nxt;
                case (state)
                    CAP_IR: ir_sr <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
                    SH_IR:  ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
                    CAP_DR: begin
                        if (sel_id) id_sr <= IDCODE_VAL;
                        else if (sel_user) begin
                            user_sr        <= user_capture_data_i;
                            user_capture_o <= 1'b1;
                        end else byp <= 1'b0;
                    end
                    SH_DR: begin
                        if (sel_id) id_sr <= {tdi, id_sr[31:1]};
                        else if (sel_user) user_sr <= {tdi, user_sr[USER_DR_WIDTH-1:1]};
                        else byp <= tdi;
                    end
                    default: ;
                endcase
            end else if (tck_fall) begin
                jtag_tdo <= state == SH_IR ? ir_sr[0] : state == SH_DR ? dr_lsb : 1'b0;
                if (state == UPD_IR) ir_o <= ir_sr;
                if (state == UPD_DR && sel_user) begin
                    user_update_data_o <= user_sr;
                    user_update_o      <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_jtag_tap_responder.sv
// tb_jtag_tap_responder: directed bench for jtag_tap_responder driving bit-banged TCK phases of 4 clk_i.
module tb_jtag_tap_responder;
`ifdef JTAG_TAP_INPUT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    logic        clk = 1'b0, rst = 1'b1;
    logic        tck = 1'b0, tms = 1'b1, tdi = 1'b0, trst_n = 1'b1;
    logic        tdo, cap, upd;
    logic [3:0]  st;
    logic [4:0]  ir;
    logic [40:0] cap_data = '0, upd_data;
    logic [63:0] d;
    int          checks = 0, errors = 0, cap_n = 0, upd_n = 0, c0, u0;

    jtag_tap_responder dut (
        .clk_i(clk), .rst_i(rst), .jtag_tck(tck), .jtag_tms(tms), .jtag_tdi(tdi),
        .jtag_trst_n(trst_n), .jtag_tdo(tdo), .tap_state_o(st), .ir_o(ir),
        .user_capture_data_i(cap_data), .user_capture_o(cap), .user_update_o(upd),
        .user_update_data_o(upd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (cap) cap_n <= cap_n + 1;
        if (upd) upd_n <= upd_n + 1;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one TCK period: low phase with new TMS/TDI, TDO sampled just before the rise
    task automatic tclk(input logic m, input logic i, output logic o);
        tms = m;
        tdi = i;
        repeat (4) @(negedge clk);
        o = tdo;
        tck = 1'b1;
        repeat (4) @(negedge clk);
        tck = 1'b0;
    endtask

    task automatic step(input logic m);
        logic o;
        tclk(m, 1'b0, o);
    endtask

    // RTI -> shift n bits LSB-first -> Update -> RTI
    task automatic shift(input logic is_ir, input int n, input logic [63:0] din, output logic [63:0] dout);
        logic o;
        dout = '0;
        step(1'b1);
        if (is_ir) step(1'b1);
        step(1'b0);
        step(1'b0);
        for (int i = 0; i < n; i++) begin
            tclk(i == n - 1, din[i], o);
            dout[i] = o;
        end
        step(1'b1);
        step(1'b0);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_state", 64'(st), 64'hF);
        check("rst_ir", 64'(ir), 64'h01);
        check("rst_tdo", 64'(tdo), 64'h0);
        check("rst_upd_data", 64'(upd_data), 64'h0);
        check("rst_pulses", 64'({cap, upd}), 64'h0);

        repeat (5) step(1'b1);
        step(1'b0);
        repeat (8) @(negedge clk);
        check("to_rti", 64'(st), 64'hC);

        c0 = cap_n;
        shift(1'b0, 32, 64'h0, d);
        check("idcode", d, 64'h1000_0CAD);
        check("idcode_no_cap", 64'(cap_n - c0), 64'h0);

        shift(1'b1, 5, 64'h1F, d);
        check("ir_capture_bypass", d, 64'h01);
        check("ir_bypass", 64'(ir), 64'h1F);
        shift(1'b0, 4, 64'hD, d);
        check("bypass_delay", d, 64'hA);

        shift(1'b1, 5, 64'h11, d);
        check("ir_capture_user", d, 64'h01);
        check("ir_user", 64'(ir), 64'h11);

        cap_data = 41'h1_2345_6789A;
        c0 = cap_n;
        u0 = upd_n;
        shift(1'b0, 41, 64'h0_DEAD_BEEF_1, d);
        check("user_capture_out", d, 64'h1_2345_6789A);
        check("user_cap_pulses", 64'(cap_n - c0), 64'h1);
        check("user_upd_pulses", 64'(upd_n - u0), 64'h1);
        check("user_upd_data", 64'(upd_data), 64'h0_DEAD_BEEF_1);
        check("user_back_rti", 64'(st), 64'hC);

        u0 = upd_n;
        step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        check("in_sh_dr", 64'(st), 64'h2);
        trst_n = 1'b0;
        repeat (1 + LAT) @(negedge clk);
        check("trst_state", 64'(st), 64'hF);
        check("trst_ir", 64'(ir), 64'h01);
        repeat (6) @(negedge clk);
        trst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("trst_no_upd", 64'(upd_n - u0), 64'h0);
        check("trst_upd_data_held", 64'(upd_data), 64'h0_DEAD_BEEF_1);

        step(1'b0);
        shift(1'b1, 5, 64'h1F, d);
        check("ir_reload", 64'(ir), 64'h1F);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        check("in_sh_ir", 64'(st), 64'hA);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_state", 64'(st), 64'hF);
        check("rst2_ir", 64'(ir), 64'h01);
        check("rst2_tdo", 64'(tdo), 64'h0);
        check("rst2_upd_data", 64'(upd_data), 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        step(1'b0);
        shift(1'b0, 32, 64'h0, d);
        check("idcode_again", d, 64'h1000_0CAD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
